// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 frame scheduler.
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    BLANK,
    DISPLAY
  } sched_state_t;

  // OE-on time for a bit plane; a zero base still lights the panel for one cycle.
  function automatic logic [31:0] weighted_period(input logic [7:0] base, input logic [31:0] plane);
    logic [31:0] unit;
    unit = (base == 8'd0) ? 32'd1 : {24'd0, base};
    return unit << plane;
  endfunction

endpackage

// File: rtl/hub75_oe_timer.sv
// Loadable down-counter; done is high during the last cycle of the loaded interval.
module hub75_oe_timer #(
  parameter int width_p = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [width_p-1:0] load_value,
  output logic               done
);

  logic [width_p-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (start) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == width_p'(1));

endmodule

// File: rtl/hub75_bcm_scheduler.sv
// Frame sequencer: walks rows and bit planes, commands the color shifter and
// drives row address / OE with binary-weighted on-times.
module hub75_bcm_scheduler
  import hub75_pkg::*;
#(
  parameter int hpixel_p   = 64,
  parameter int vpixel_p   = 64,
  parameter int bpp_p      = 8,
  parameter int segments_p = 2,
  parameter int blank_p    = 2,
  localparam int rows_p          = vpixel_p / segments_p,
  localparam int row_width_p     = $clog2(rows_p),
  localparam int addr_width_p    = $clog2(hpixel_p * vpixel_p),
  localparam int pix_bit_width_p = $clog2(bpp_p)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_enable,
  input  logic [7:0]                 i_base_period,
  output logic                       o_busy,
  output logic                       o_frame_done,
  output logic                       o_tx_start,
  output logic [addr_width_p-1:0]    o_init_addr,
  output logic [pix_bit_width_p-1:0] o_pix_bit,
  input  logic                       i_tx_ready,
  output logic [row_width_p-1:0]     o_row_addr,
  output logic                       o_oe_n
);

  localparam int timer_width_p = 8 + bpp_p;
  localparam logic [row_width_p-1:0]     last_row_c   = row_width_p'(rows_p - 1);
  localparam logic [pix_bit_width_p-1:0] last_plane_c = pix_bit_width_p'(bpp_p - 1);

  sched_state_t                 state_q, state_d;
  logic [row_width_p-1:0]       row_q, row_d;
  logic [pix_bit_width_p-1:0]   plane_q, plane_d;
  logic [7:0]                   base_q, base_d;
  logic                         guard_q, guard_d;

  logic                         tx_start_d, oe_n_d, frame_done_d;
  logic [addr_width_p-1:0]      init_addr_d;
  logic [pix_bit_width_p-1:0]   pix_bit_d;
  logic [row_width_p-1:0]       row_addr_d;

  logic                         timer_start, timer_done;
  logic [timer_width_p-1:0]     timer_value, display_period;

  assign display_period = timer_width_p'(weighted_period(base_q, 32'(plane_q)));

  hub75_oe_timer #(.width_p(timer_width_p)) u_oe_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (timer_start),
    .load_value (timer_value),
    .done       (timer_done)
  );

  // Outputs are computed for the state being entered so the registered
  // versions line up exactly with the state they belong to.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    plane_d      = plane_q;
    base_d       = base_q;
    guard_d      = 1'b0;
    tx_start_d   = 1'b0;
    init_addr_d  = o_init_addr;
    pix_bit_d    = o_pix_bit;
    row_addr_d   = o_row_addr;
    oe_n_d       = 1'b1;
    frame_done_d = 1'b0;
    timer_start  = 1'b0;
    timer_value  = timer_width_p'(blank_p);

    case (state_q)
      IDLE: begin
        if (i_enable && i_tx_ready) begin
          row_d   = '0;
          plane_d = '0;
          state_d = START;
        end
      end
      START: begin
        if (i_tx_ready) begin
          tx_start_d  = 1'b1;
          init_addr_d = addr_width_p'(row_q) * addr_width_p'(hpixel_p);
          pix_bit_d   = plane_q;
          base_d      = i_base_period;
          guard_d     = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        // The shifter only drops ready after it has seen the start pulse.
        if (!guard_q && i_tx_ready) begin
          row_addr_d  = row_q;
          timer_start = 1'b1;
          timer_value = timer_width_p'(blank_p);
          state_d     = BLANK;
        end
      end
      BLANK: begin
        if (timer_done) begin
          timer_start = 1'b1;
          timer_value = display_period;
          oe_n_d      = 1'b0;
          state_d     = DISPLAY;
        end
      end
      DISPLAY: begin
        if (!timer_done) begin
          oe_n_d = 1'b0;
        end else if (plane_q != last_plane_c) begin
          plane_d = plane_q + 1'b1;
          state_d = START;
        end else begin
          plane_d = '0;
          if (row_q != last_row_c) begin
            row_d   = row_q + 1'b1;
            state_d = START;
          end else begin
            row_d        = '0;
            frame_done_d = 1'b1;
            state_d      = i_enable ? START : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      row_q        <= '0;
      plane_q      <= '0;
      base_q       <= '0;
      guard_q      <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_tx_start   <= 1'b0;
      o_init_addr  <= '0;
      o_pix_bit    <= '0;
      o_row_addr   <= '0;
      o_oe_n       <= 1'b1;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      base_q       <= base_d;
      guard_q      <= guard_d;
      o_busy       <= (state_d != IDLE);
      o_frame_done <= frame_done_d;
      o_tx_start   <= tx_start_d;
      o_init_addr  <= init_addr_d;
      o_pix_bit    <= pix_bit_d;
      o_row_addr   <= row_addr_d;
      o_oe_n       <= oe_n_d;
    end
  end

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Self-checking bench for hub75_bcm_scheduler: directed vector table, corner
// sequences, and a randomized run watched by a plane-level reference monitor.
module tb_hub75_bcm_scheduler;

  localparam int hpixel_p    = 4;
  localparam int vpixel_p    = 4;
  localparam int segments_p  = 2;
  localparam int bpp_p       = 2;
  localparam int blank_p     = 2;
  localparam int rows_p      = vpixel_p / segments_p;
  localparam int shift_low_c = 10;
  // START + guard + shifter busy + ready cycle + blanking
  localparam int plane_overhead_c = 1 + 1 + shift_low_c + 1 + blank_p;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_enable = 1'b0;
  logic [7:0] i_base_period = 8'd0;
  logic       i_tx_ready;
  logic       o_busy, o_frame_done, o_tx_start, o_oe_n;
  logic [3:0] o_init_addr;
  logic [0:0] o_pix_bit;
  logic [0:0] o_row_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int extra_stall = 0;
  int shift_cnt = 0;

  always #5 clk = ~clk;

  hub75_bcm_scheduler #(
    .hpixel_p   (hpixel_p),
    .vpixel_p   (vpixel_p),
    .bpp_p      (bpp_p),
    .segments_p (segments_p),
    .blank_p    (blank_p)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_enable      (i_enable),
    .i_base_period (i_base_period),
    .o_busy        (o_busy),
    .o_frame_done  (o_frame_done),
    .o_tx_start    (o_tx_start),
    .o_init_addr   (o_init_addr),
    .o_pix_bit     (o_pix_bit),
    .i_tx_ready    (i_tx_ready),
    .o_row_addr    (o_row_addr),
    .o_oe_n        (o_oe_n)
  );

  // Color shifter stand-in: busy for a fixed time (plus optional stall) after each start.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) shift_cnt <= 0;
    else if (o_tx_start) shift_cnt <= shift_low_c + extra_stall;
    else if (shift_cnt != 0) shift_cnt <= shift_cnt - 1;
  end
  assign i_tx_ready = (shift_cnt == 0);

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  // Reference monitor: tracks the frame as a list of planes (row-major, then bit).
  int       plane_k = 0;
  int       exp_width = 0;
  int       exp_row = 0;
  bit       width_pending = 1'b0;
  int       run_len = 0;
  bit       prev_oe_n = 1'b1;
  bit       prev_done = 1'b0;
  logic [0:0] prev_row = 1'b0;
  bit       wait_ready = 1'b0;
  int       ready_cyc = -1;
  int       row_chg_cyc = -1;
  int       done_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      plane_k       = 0;
      width_pending = 1'b0;
      wait_ready    = 1'b0;
      ready_cyc     = -1;
      row_chg_cyc   = -1;
      run_len       = 0;
    end else begin
      if (!i_tx_ready) checkOutput("oe_off_while_shifting", int'(o_oe_n), 1);
      if (wait_ready && i_tx_ready) begin
        ready_cyc  = cyc;
        wait_ready = 1'b0;
      end
      if (o_tx_start) begin
        checkOutput("mon_init_addr", int'(o_init_addr), (plane_k / bpp_p) * hpixel_p);
        checkOutput("mon_pix_bit", int'(o_pix_bit), plane_k % bpp_p);
        checkOutput("mon_start_while_busy", int'(i_tx_ready), 1);
        checkOutput("mon_start_before_display_end", int'(width_pending), 0);
        exp_width = ((i_base_period == 8'd0) ? 1 : int'(i_base_period)) << (plane_k % bpp_p);
        exp_row       = plane_k / bpp_p;
        width_pending = 1'b1;
        wait_ready    = 1'b1;
        ready_cyc     = -1;
        plane_k++;
      end
      if (o_row_addr != prev_row) begin
        checkOutput("mon_oe_at_row_change", int'({prev_oe_n, o_oe_n}), 3);
        row_chg_cyc = cyc;
      end
      if (prev_oe_n && !o_oe_n) begin
        checkOutput("mon_display_has_plane", int'(width_pending), 1);
        checkOutput("mon_row_at_display", int'(o_row_addr), exp_row);
        if (ready_cyc >= 0) checkOutput("mon_ready_to_display", cyc - ready_cyc, blank_p + 1);
        if (row_chg_cyc >= 0) checkOutput("mon_blank_after_row_change", cyc - row_chg_cyc, blank_p);
        row_chg_cyc = -1;
        run_len = 0;
      end
      if (!o_oe_n) run_len++;
      if (!prev_oe_n && o_oe_n) begin
        checkOutput("mon_oe_width", run_len, exp_width);
        width_pending = 1'b0;
      end
      if (o_frame_done) begin
        checkOutput("mon_done_single_cycle", int'(prev_done), 0);
        checkOutput("mon_done_after_last_plane", plane_k, rows_p * bpp_p);
        checkOutput("mon_done_display_finished", int'(width_pending), 0);
        done_cnt++;
        plane_k = 0;
      end
    end
    prev_oe_n = o_oe_n;
    prev_row  = o_row_addr;
    prev_done = o_frame_done;
  end

  typedef struct {
    logic [7:0] base;
    int         stall;
    bit         enable;
    int         exp_addr;
    int         exp_bit;
    int         exp_width;
    bit         exp_done;
  } vec_t;

  vec_t vecs[8];

  task automatic applyStimulus(input vec_t v);
    i_base_period = v.base;
    extra_stall   = v.stall;
    i_enable      = v.enable;
  endtask

  initial begin
    int t, w, n, b, start_done, exp_frame;
    int times[4];

    vecs[0] = '{8'd3, 0,  1'b1, 0, 0, 3, 1'b0};
    vecs[1] = '{8'd3, 0,  1'b1, 0, 1, 6, 1'b0};
    vecs[2] = '{8'd3, 50, 1'b1, 4, 0, 3, 1'b0};
    vecs[3] = '{8'd3, 0,  1'b1, 4, 1, 6, 1'b1};
    vecs[4] = '{8'd0, 0,  1'b1, 0, 0, 1, 1'b0};
    vecs[5] = '{8'd0, 0,  1'b0, 0, 1, 2, 1'b0};
    vecs[6] = '{8'd0, 0,  1'b0, 4, 0, 1, 1'b0};
    vecs[7] = '{8'd0, 0,  1'b0, 4, 1, 2, 1'b1};

    repeat (3) @(negedge clk);
    checkOutput("reset_oe_n", int'(o_oe_n), 1);
    checkOutput("reset_tx_start", int'(o_tx_start), 0);
    checkOutput("reset_busy", int'(o_busy), 0);
    checkOutput("reset_frame_done", int'(o_frame_done), 0);
    checkOutput("reset_row_addr", int'(o_row_addr), 0);
    checkOutput("reset_init_addr", int'(o_init_addr), 0);
    checkOutput("reset_pix_bit", int'(o_pix_bit), 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_without_enable", int'(o_busy), 0);

    // Two directed frames: base 3 with a long shifter stall, then base 0 with enable dropped mid-frame.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      t = 0;
      while (!o_tx_start && t < 200) begin @(negedge clk); t++; end
      checkOutput($sformatf("vec%0d_start_seen", i), int'(o_tx_start), 1);
      checkOutput($sformatf("vec%0d_init_addr", i), int'(o_init_addr), vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d_pix_bit", i), int'(o_pix_bit), vecs[i].exp_bit);
      t = 0;
      while (o_oe_n && t < 200) begin @(negedge clk); t++; end
      checkOutput($sformatf("vec%0d_oe_low_seen", i), int'(o_oe_n), 0);
      w = 0;
      while (!o_oe_n && w < 2000) begin @(negedge clk); w++; end
      checkOutput($sformatf("vec%0d_oe_width", i), w, vecs[i].exp_width);
      checkOutput($sformatf("vec%0d_frame_done", i), int'(o_frame_done), int'(vecs[i].exp_done));
    end
    checkOutput("table_busy_after_last_frame", int'(o_busy), 0);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_tx_start || o_busy) n++;
    end
    checkOutput("stays_idle_after_disable", n, 0);
    checkOutput("table_frame_count", done_cnt, 2);

    // Reset in the middle of a row-1 DISPLAY, then restart from the top.
    i_base_period = 8'd20;
    i_enable = 1'b1;
    t = 0;
    while (!(o_tx_start && o_init_addr == 4'd4) && t < 2000) begin @(negedge clk); t++; end
    checkOutput("row1_start_seen", int'(o_tx_start), 1);
    t = 0;
    while (o_oe_n && t < 200) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    checkOutput("row_before_reset", int'(o_row_addr), 1);
    checkOutput("oe_before_reset", int'(o_oe_n), 0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_oe_n", int'(o_oe_n), 1);
    checkOutput("midreset_row_addr", int'(o_row_addr), 0);
    checkOutput("midreset_busy", int'(o_busy), 0);
    checkOutput("midreset_tx_start", int'(o_tx_start), 0);
    rst_n = 1'b1;
    t = 0;
    while (!o_tx_start && t < 100) begin @(negedge clk); t++; end
    checkOutput("restart_start_seen", int'(o_tx_start), 1);
    checkOutput("restart_init_addr", int'(o_init_addr), 0);
    checkOutput("restart_pix_bit", int'(o_pix_bit), 0);

    // Continuous run with a fixed base: frame_done pulses must be evenly spaced.
    b = $urandom_range(1, 30);
    i_base_period = 8'(b);
    extra_stall = 0;
    exp_frame = 0;
    for (int r = 0; r < rows_p; r++)
      for (int k = 0; k < bpp_p; k++)
        exp_frame += plane_overhead_c + (b << k);
    n = 0;
    t = 0;
    while (n < 4 && t < 20000) begin
      @(negedge clk);
      t++;
      if (o_frame_done) begin times[n] = cyc; n++; end
    end
    checkOutput("spacing_pulse_count", n, 4);
    if (n == 4) begin
      checkOutput("frame_spacing_1", times[1] - times[0], exp_frame);
      checkOutput("frame_spacing_2", times[2] - times[1], exp_frame);
      checkOutput("frame_spacing_3", times[3] - times[2], exp_frame);
    end

    // Randomized run: base and stall change only while the panel is lit.
    start_done = done_cnt;
    t = 0;
    while (done_cnt < start_done + 3 && t < 40000) begin
      @(negedge clk);
      t++;
      if (!o_oe_n && $urandom_range(0, 5) == 0) begin
        i_base_period = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
        extra_stall   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
      end
    end
    checkOutput("random_frames_done", done_cnt - start_done, 3);

    i_enable = 1'b0;
    t = 0;
    while (o_busy && t < 5000) begin @(negedge clk); t++; end
    checkOutput("final_idle", int'(o_busy), 0);
    checkOutput("final_oe_n", int'(o_oe_n), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
